// File: rtl/dmem_cache_responder.sv
// Memory-stage data responder: direct-mapped, write-back cache with one word per line,
// backed by an internal word array with a fixed access latency.
module dmem_cache_responder #(
   parameter int IDX_W   = 3,
   parameter int MEM_AW  = 10,
   parameter int MEM_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   input  logic        createdump,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        CacheHit,
   output logic        err
);
   localparam int LINES     = 1 << IDX_W;
   localparam int TAG_W     = 15 - IDX_W;
   localparam int LAT_W     = $clog2(MEM_LAT + 1);
   localparam int MEM_WORDS = 1 << MEM_AW;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WB    = 3'd1,
      FILL  = 3'd2,
      RESP  = 3'd3,
      FLUSH = 3'd4,
      FDONE = 3'd5
   } state_t;

   state_t state_reg;

   logic [15:0]      mem       [MEM_WORDS];
   logic [15:0]      line_data [LINES];
   logic [TAG_W-1:0] line_tag  [LINES];
   logic [LINES-1:0] valid_reg;
   logic [LINES-1:0] dirty_reg;

   logic [15:1]      req_addr_reg;
   logic [15:0]      req_din_reg;
   logic             req_wr_reg;
   logic [LAT_W-1:0] lat_cnt_reg;
   logic [IDX_W-1:0] idx_cnt_reg;
   logic [15:0]      dout_reg;
   logic [15:0]      dout_next;

   logic [IDX_W-1:0]  in_idx;
   logic [TAG_W-1:0]  in_tag;
   logic              in_hit;
   logic              in_illegal;
   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic [MEM_AW-1:0] req_word;
   logic [IDX_W-1:0]  wb_idx;
   logic [MEM_AW-1:0] wb_word;
   logic              lat_last;
   logic              flush_dirty;

   assign in_idx     = Addr[IDX_W:1];
   assign in_tag     = Addr[15:IDX_W+1];
   assign in_hit     = valid_reg[in_idx] && (line_tag[in_idx] == in_tag);
   assign in_illegal = (Rd && Wr) || ((Rd || Wr) && Addr[0]);

   assign req_idx  = req_addr_reg[IDX_W:1];
   assign req_tag  = req_addr_reg[15:IDX_W+1];
   assign req_word = req_addr_reg[MEM_AW:1];

   // A victim's backing word is rebuilt from its stored tag and its index.
   assign wb_idx      = (state_reg == FLUSH) ? idx_cnt_reg : req_idx;
   assign wb_word     = MEM_AW'({line_tag[wb_idx], wb_idx});
   assign lat_last    = (lat_cnt_reg == LAT_LAST);
   assign flush_dirty = valid_reg[idx_cnt_reg] && dirty_reg[idx_cnt_reg];

   always_comb begin
      dout_next = dout_reg;
      Stall     = 1'b0;
      Done      = 1'b0;
      CacheHit  = 1'b0;
      err       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (createdump) begin
               Stall = 1'b1;
            end else if (in_illegal) begin
               err = 1'b1;
            end else if (Rd || Wr) begin
               if (in_hit) begin
                  Done     = 1'b1;
                  CacheHit = 1'b1;
                  if (Rd) begin
                     dout_next = line_data[in_idx];
                  end
               end else begin
                  Stall = 1'b1;
               end
            end
         end
         WB, FILL, FLUSH: Stall = 1'b1;
         RESP: begin
            Done      = 1'b1;
            dout_next = req_wr_reg ? req_din_reg : line_data[req_idx];
         end
         FDONE:   Done = 1'b1;
         default: err  = 1'b1;
      endcase
   end

   assign DataOut = dout_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         valid_reg    <= '0;
         dirty_reg    <= '0;
         req_addr_reg <= '0;
         req_din_reg  <= '0;
         req_wr_reg   <= 1'b0;
         lat_cnt_reg  <= '0;
         idx_cnt_reg  <= '0;
         dout_reg     <= '0;
         for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else begin
         dout_reg <= dout_next;
         case (state_reg)
            IDLE: begin
               if (createdump) begin
                  state_reg   <= FLUSH;
                  idx_cnt_reg <= '0;
                  lat_cnt_reg <= '0;
               end else if (!in_illegal && (Rd || Wr)) begin
                  if (in_hit) begin
                     if (Wr) begin
                        line_data[in_idx] <= DataIn;
                        dirty_reg[in_idx] <= 1'b1;
                     end
                  end else begin
                     req_addr_reg <= Addr[15:1];
                     req_din_reg  <= DataIn;
                     req_wr_reg   <= Wr;
                     lat_cnt_reg  <= '0;
                     if (valid_reg[in_idx] && dirty_reg[in_idx]) begin
                        state_reg <= WB;
                     end else begin
                        state_reg <= FILL;
                     end
                  end
               end
            end
            WB: begin
               if (lat_last) begin
                  mem[wb_word] <= line_data[req_idx];
                  lat_cnt_reg  <= '0;
                  state_reg    <= FILL;
               end else begin
                  lat_cnt_reg <= lat_cnt_reg + 1'b1;
               end
            end
            FILL: begin
               if (lat_last) begin
                  line_data[req_idx] <= req_wr_reg ? req_din_reg : mem[req_word];
                  line_tag[req_idx]  <= req_tag;
                  valid_reg[req_idx] <= 1'b1;
                  dirty_reg[req_idx] <= req_wr_reg;
                  lat_cnt_reg        <= '0;
                  state_reg          <= RESP;
               end else begin
                  lat_cnt_reg <= lat_cnt_reg + 1'b1;
               end
            end
            RESP: state_reg <= IDLE;
            FLUSH: begin
               // Clean lines take one cycle; dirty ones wait out the backing latency.
               if (flush_dirty && !lat_last) begin
                  lat_cnt_reg <= lat_cnt_reg + 1'b1;
               end else begin
                  if (flush_dirty) begin
                     mem[wb_word]           <= line_data[idx_cnt_reg];
                     dirty_reg[idx_cnt_reg] <= 1'b0;
                  end
                  lat_cnt_reg <= '0;
                  idx_cnt_reg <= idx_cnt_reg + 1'b1;
                  if (idx_cnt_reg == IDX_LAST) begin
                     state_reg <= FDONE;
                  end
               end
            end
            FDONE:   state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule
